// File: rtl/mmio_router.sv
// mmio_router: canonical check plus base/mask window decode, one outstanding MMIO transaction.
// Optional slave timeout is compiled in when MMIO_ROUTER_TIMEOUT_EN is defined.
module mmio_router #(
    parameter int NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*47-1:0] SLAVE_BASE = {47'h4000_0000_8000, 47'h4000_0000_4000,
                                                      47'h4000_0004_0000, 47'h4000_0000_0000},
    parameter logic [NUM_SLAVES*47-1:0] SLAVE_MASK = {47'h7FFF_FFFF_C000, 47'h7FFF_FFFF_C000,
                                                      47'h7FFF_FFFC_0000, 47'h4000_0000_0000},
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_req_valid,
    output logic                       m_req_ready,
    input  logic [63:0]                m_addr,
    input  logic                       m_we,
    input  logic [63:0]                m_wdata,
    input  logic [7:0]                 m_be,
    output logic                       m_resp_valid,
    output logic [63:0]                m_rdata,
    output logic                       m_err,
    output logic [NUM_SLAVES-1:0]      s_req_valid,
    input  logic [NUM_SLAVES-1:0]      s_req_ready,
    output logic [63:0]                s_addr,
    output logic                       s_we,
    output logic [63:0]                s_wdata,
    output logic [7:0]                 s_be,
    input  logic [NUM_SLAVES-1:0]      s_resp_valid,
    input  logic [NUM_SLAVES*64-1:0]   s_rdata
);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_badParams
        $error("mmio_router: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t                 r_state;
    logic [NUM_SLAVES-1:0]  r_sel;

    logic                   w_canon;
    logic [NUM_SLAVES-1:0]  w_hit;
    logic [NUM_SLAVES-1:0]  w_selOh;
    logic                   w_miss;
    logic                   w_reqAck;
    logic                   w_respHit;
    logic                   w_expire;
    logic [63:0]            w_rdataSel;

    assign w_canon = (&m_addr[63:47]) | ~(|m_addr[63:47]);

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_hit[i] = ((m_addr[46:0] & SLAVE_MASK[i*47 +: 47]) ==
                        (SLAVE_BASE[i*47 +: 47] & SLAVE_MASK[i*47 +: 47]));
        end
    end

    // Isolate the lowest set bit so the lowest-index window wins on overlap.
    assign w_selOh   = w_hit & (~w_hit + NUM_SLAVES'(1));
    assign w_miss    = ~w_canon | ~(|w_hit);
    assign w_reqAck  = |(s_req_ready & r_sel);
    assign w_respHit = |(s_resp_valid & r_sel);

    always_comb begin
        w_rdataSel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel[i]) w_rdataSel = w_rdataSel | s_rdata[i*64 +: 64];
        end
    end

`ifdef MMIO_ROUTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_cnt;

    // Held at zero outside REQ/RESP, so each transaction starts counting from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == REQ || r_state == RESP) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_expire = (r_cnt == TO_LAST);
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            m_req_ready  <= 1'b1;
            m_resp_valid <= 1'b0;
            m_rdata      <= '0;
            m_err        <= 1'b0;
            s_req_valid  <= '0;
            s_addr       <= '0;
            s_we         <= 1'b0;
            s_wdata      <= '0;
            s_be         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m_req_valid) begin
                        s_addr      <= m_addr;
                        s_we        <= m_we;
                        s_wdata     <= m_wdata;
                        s_be        <= m_be;
                        m_req_ready <= 1'b0;
                        if (w_miss) begin
                            r_sel        <= '0;
                            m_rdata      <= '0;
                            m_err        <= 1'b1;
                            m_resp_valid <= 1'b1;
                            r_state      <= DONE;
                        end else begin
                            r_sel       <= w_selOh;
                            s_req_valid <= w_selOh;
                            r_state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (w_expire) begin
                        s_req_valid  <= '0;
                        m_rdata      <= '0;
                        m_err        <= 1'b1;
                        m_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end else if (w_reqAck) begin
                        s_req_valid <= '0;
                        r_state     <= RESP;
                    end
                end
                // A response in the expiry cycle takes priority over the timeout.
                RESP: begin
                    if (w_respHit) begin
                        m_rdata      <= w_rdataSel;
                        m_err        <= 1'b0;
                        m_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end else if (w_expire) begin
                        m_rdata      <= '0;
                        m_err        <= 1'b1;
                        m_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    m_resp_valid <= 1'b0;
                    m_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_router.sv
// Scoreboard bench for mmio_router: directed requests push expected responses,
// a negedge monitor pops and compares whenever m_resp_valid is seen.
module tb_mmio_router;

    localparam int NS = 4;
    // Window map chosen so every channel is reachable: ch0 is a 4 KiB window at 0x1000,
    // ch1 a 16 KiB window at 0x4000_0000_4000, ch2 the whole bit46=0 half (overlapping ch0),
    // ch3 a 256 KiB window at 0x4000_0004_0000.
    localparam logic [NS*47-1:0] BASE = {47'h4000_0004_0000, 47'h0000_0000_0000,
                                         47'h4000_0000_4000, 47'h0000_0000_1000};
    localparam logic [NS*47-1:0] MASK = {47'h7FFF_FFFC_0000, 47'h4000_0000_0000,
                                         47'h7FFF_FFFF_C000, 47'h7FFF_FFFF_F000};

    logic            clk = 1'b0;
    logic            rst_n;
    logic            m_req_valid;
    logic            m_req_ready;
    logic [63:0]     m_addr;
    logic            m_we;
    logic [63:0]     m_wdata;
    logic [7:0]      m_be;
    logic            m_resp_valid;
    logic [63:0]     m_rdata;
    logic            m_err;
    logic [NS-1:0]   s_req_valid;
    logic [NS-1:0]   s_req_ready;
    logic [63:0]     s_addr;
    logic            s_we;
    logic [63:0]     s_wdata;
    logic [7:0]      s_be;
    logic [NS-1:0]   s_resp_valid;
    logic [NS*64-1:0] s_rdata;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic        chkData;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   checks = 0;
    int   failures = 0;

    mmio_router #(
        .NUM_SLAVES(NS),
        .SLAVE_BASE(BASE),
        .SLAVE_MASK(MASK),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .m_req_valid(m_req_valid),
        .m_req_ready(m_req_ready),
        .m_addr(m_addr),
        .m_we(m_we),
        .m_wdata(m_wdata),
        .m_be(m_be),
        .m_resp_valid(m_resp_valid),
        .m_rdata(m_rdata),
        .m_err(m_err),
        .s_req_valid(s_req_valid),
        .s_req_ready(s_req_ready),
        .s_addr(s_addr),
        .s_we(s_we),
        .s_wdata(s_wdata),
        .s_be(s_be),
        .s_resp_valid(s_resp_valid),
        .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && m_resp_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_resp", 64'd1, 64'd0);
            end else begin
                monE = expQ.pop_front();
                checkOutput("resp_err", 64'(m_err), 64'(monE.err));
                if (monE.chkData) checkOutput("resp_rdata", m_rdata, monE.rdata);
            end
        end
    end

    // Called at a negedge with the router idle; returns at the negedge of the cycle after accept.
    task automatic applyStimulus(input logic [63:0] addr, input logic we,
                                 input logic [63:0] wdata, input logic [7:0] be);
        checkOutput("req_ready_idle", 64'(m_req_ready), 64'd1);
        m_addr      = addr;
        m_we        = we;
        m_wdata     = wdata;
        m_be        = be;
        m_req_valid = 1'b1;
        @(negedge clk);
        m_req_valid = 1'b0;
    endtask

    task automatic doRead(input logic [63:0] addr, input int ch, input logic [63:0] data);
        expQ.push_back('{data, 1'b0, 1'b1});
        applyStimulus(addr, 1'b0, 64'h0, 8'hFF);
        checkOutput("rd_sel", 64'(s_req_valid), 64'(1 << ch));
        checkOutput("rd_s_addr", s_addr, addr);
        checkOutput("rd_s_we", 64'(s_we), 64'd0);
        s_req_ready = NS'(1 << ch);
        @(negedge clk);
        checkOutput("rd_req_drop", 64'(s_req_valid), 64'd0);
        checkOutput("rd_no_early_resp", 64'(m_resp_valid), 64'd0);
        s_req_ready  = '0;
        s_resp_valid = NS'(1 << ch);
        s_rdata[ch*64 +: 64] = data;
        @(negedge clk);
        s_resp_valid = '0;
        checkOutput("rd_resp_latency", 64'(m_resp_valid), 64'd1);
        checkOutput("rd_sreq_quiet", 64'(s_req_valid), 64'd0);
        @(negedge clk);
        checkOutput("rd_resp_one_cycle", 64'(m_resp_valid), 64'd0);
        checkOutput("rd_ready_back", 64'(m_req_ready), 64'd1);
    endtask

    logic [63:0] missAddr [2] = '{64'h0001_0000_0000_0000, 64'h0000_4000_0010_0000};

    initial begin
        rst_n        = 1'b0;
        m_req_valid  = 1'b0;
        m_addr       = '0;
        m_we         = 1'b0;
        m_wdata      = '0;
        m_be         = '0;
        s_req_ready  = '0;
        s_resp_valid = '0;
        s_rdata      = '0;

        @(negedge clk);
        checkOutput("rst_req_ready", 64'(m_req_ready), 64'd1);
        checkOutput("rst_resp_valid", 64'(m_resp_valid), 64'd0);
        checkOutput("rst_rdata", m_rdata, 64'd0);
        checkOutput("rst_err", 64'(m_err), 64'd0);
        checkOutput("rst_s_req_valid", 64'(s_req_valid), 64'd0);
        checkOutput("rst_s_addr", s_addr, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] read on ch1, zero-wait slave");
        doRead(64'h0000_4000_0000_4010, 1, 64'hDEAD_BEEF_0123_4567);

        $display("[TB] read on ch1 via upper canonical half");
        doRead(64'hFFFF_C000_0000_4010, 1, 64'h0F0F_1234_5678_9ABC);

        $display("[TB] write on ch0, overlapped by ch2");
        expQ.push_back('{64'h0, 1'b0, 1'b0});
        applyStimulus(64'h0000_0000_0000_1000, 1'b1, 64'h1122_3344_5566_7788, 8'h0F);
        checkOutput("wr_sel", 64'(s_req_valid), 64'h1);
        checkOutput("wr_s_addr", s_addr, 64'h0000_0000_0000_1000);
        checkOutput("wr_s_we", 64'(s_we), 64'd1);
        checkOutput("wr_s_wdata", s_wdata, 64'h1122_3344_5566_7788);
        checkOutput("wr_s_be", 64'(s_be), 64'h0F);
        s_req_ready = 4'b0001;
        @(negedge clk);
        s_req_ready  = '0;
        s_resp_valid = 4'b0001;
        s_rdata[63:0] = 64'hAAAA_5555_AAAA_5555;
        @(negedge clk);
        s_resp_valid = '0;
        checkOutput("wr_resp", 64'(m_resp_valid), 64'd1);
        @(negedge clk);

        $display("[TB] decode misses");
        for (int i = 0; i < 2; i++) begin
            expQ.push_back('{64'h0, 1'b1, 1'b1});
            applyStimulus(missAddr[i], 1'b0, 64'h0, 8'hFF);
            checkOutput("miss_resp", 64'(m_resp_valid), 64'd1);
            checkOutput("miss_no_sreq", 64'(s_req_valid), 64'd0);
            checkOutput("miss_not_ready", 64'(m_req_ready), 64'd0);
            @(negedge clk);
            checkOutput("miss_one_cycle", 64'(m_resp_valid), 64'd0);
            checkOutput("miss_ready_back", 64'(m_req_ready), 64'd1);
        end

        $display("[TB] stalled ch1 slave with stray responses");
        expQ.push_back('{64'h0123_4567_89AB_CDEF, 1'b0, 1'b1});
        applyStimulus(64'h0000_4000_0000_4020, 1'b0, 64'h0, 8'hFF);
        for (int k = 1; k <= 6; k++) begin
            checkOutput("stall_req_held", 64'(s_req_valid), 64'h2);
            checkOutput("stall_not_ready", 64'(m_req_ready), 64'd0);
            checkOutput("stall_no_resp", 64'(m_resp_valid), 64'd0);
            s_req_ready  = (k == 6) ? 4'b0010 : 4'b0000;
            s_resp_valid = (k == 3) ? 4'b0010 : 4'b0000;
            s_rdata[127:64] = 64'hBAD0_BAD0_BAD0_BAD0;
            @(negedge clk);
        end
        checkOutput("stall_req_drop", 64'(s_req_valid), 64'd0);
        s_req_ready  = '0;
        s_resp_valid = 4'b0100;
        s_rdata[191:128] = 64'hFFFF_0000_FFFF_0000;
        s_rdata[127:64]  = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        checkOutput("stray_ignored", 64'(m_resp_valid), 64'd0);
        s_resp_valid = '0;
        @(negedge clk);
        checkOutput("stall_wait", 64'(m_resp_valid), 64'd0);
        checkOutput("stall_busy", 64'(m_req_ready), 64'd0);
        s_resp_valid = 4'b0010;
        @(negedge clk);
        s_resp_valid = '0;
        checkOutput("stall_resp", 64'(m_resp_valid), 64'd1);
        @(negedge clk);

`ifdef MMIO_ROUTER_TIMEOUT_EN
        $display("[TB] slave timeout");
        expQ.push_back('{64'h0, 1'b1, 1'b1});
        applyStimulus(64'h0000_4000_0000_4030, 1'b0, 64'h0, 8'hFF);
        for (int k = 1; k <= 8; k++) begin
            checkOutput("to_wait", 64'(m_resp_valid), 64'd0);
            checkOutput("to_req_held", 64'(s_req_valid), 64'h2);
            @(negedge clk);
        end
        checkOutput("to_resp", 64'(m_resp_valid), 64'd1);
        checkOutput("to_req_drop", 64'(s_req_valid), 64'd0);
        @(negedge clk);
        s_resp_valid = 4'b0010;
        s_rdata[127:64] = 64'h7777_7777_7777_7777;
        @(negedge clk);
        checkOutput("to_late_ignored", 64'(m_resp_valid), 64'd0);
        s_resp_valid = '0;
        @(negedge clk);
        checkOutput("to_idle", 64'(m_req_ready), 64'd1);
`else
        $display("[TB] slow slave without timeout");
        expQ.push_back('{64'h5A5A_A5A5_0000_1111, 1'b0, 1'b1});
        applyStimulus(64'h0000_4000_0000_4030, 1'b0, 64'h0, 8'hFF);
        for (int k = 1; k <= 20; k++) @(negedge clk);
        checkOutput("slow_req_held", 64'(s_req_valid), 64'h2);
        checkOutput("slow_busy", 64'(m_req_ready), 64'd0);
        s_req_ready = 4'b0010;
        @(negedge clk);
        s_req_ready = '0;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        checkOutput("slow_still_waiting", 64'(m_req_ready), 64'd0);
        s_resp_valid = 4'b0010;
        s_rdata[127:64] = 64'h5A5A_A5A5_0000_1111;
        @(negedge clk);
        s_resp_valid = '0;
        checkOutput("slow_resp", 64'(m_resp_valid), 64'd1);
        @(negedge clk);
`endif

        $display("[TB] reset during RESP");
        applyStimulus(64'h0000_4000_0000_4040, 1'b0, 64'h0, 8'hFF);
        s_req_ready = 4'b0010;
        @(negedge clk);
        s_req_ready = '0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstmid_sreq", 64'(s_req_valid), 64'd0);
        checkOutput("rstmid_resp", 64'(m_resp_valid), 64'd0);
        checkOutput("rstmid_ready", 64'(m_req_ready), 64'd1);
        checkOutput("rstmid_s_addr", s_addr, 64'd0);
        @(negedge clk);
        s_resp_valid = 4'b0010;
        s_rdata[127:64] = 64'h9999_8888_7777_6666;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_late_ignored", 64'(m_resp_valid), 64'd0);
        checkOutput("rstmid_idle", 64'(m_req_ready), 64'd1);
        s_resp_valid = '0;
        @(negedge clk);
        checkOutput("rstmid_quiet", 64'(m_resp_valid), 64'd0);
        doRead(64'h0000_0000_0020_0000, 2, 64'hCAFE_F00D_1357_2468);

        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
